uart_rx: RTL and testbench

- UART receiver; the receive-side counterpart of the team's UART transmitter. Shares the same baud TICK (16x oversample enable), N_BIT/N_TICK parameters and 2-bit STATE debug encoding.
- Frame format: 1 start bit (0), N_BIT data bits LSB first, 1 stop bit (1), no parity.
- Features: synchronizes the asynchronous RX line, rejects false starts, majority-votes each bit at mid-point, and holds received bytes in a one-entry buffer with READY/ACK handshake and overrun/framing flags.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame parameters,
// common to the transmitter and the receiver.
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] DATA  = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

    localparam int UART_N_BIT  = 8;
    localparam int UART_N_TICK = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_START = START,
        ST_DATA  = DATA,
        ST_STOP  = STOP
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line plus a delay flop for
// falling-edge detection. All flops reset to the idle (high) line level.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start/data/stop framing with 3-sample
// majority vote at each bit centre and a one-entry READY/ACK output buffer.
module uart_rx
    import uart_pkg::*;
#(
    parameter int N_BIT  = UART_N_BIT,
    parameter int N_TICK = UART_N_TICK
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             TICK,
    input  logic             RX,
    input  logic             RD_ACK,
    output logic [N_BIT-1:0] DOUT,
    output logic             RX_DONE,
    output logic             RX_READY,
    output logic             OVERRUN,
    output logic             FRAME_ERR,
    output logic [1:0]       STATE
);

    localparam int SW = $clog2(N_TICK);
    localparam int NW = $clog2(N_BIT);
    localparam logic [SW-1:0] S_MID  = SW'(N_TICK / 2);
    localparam logic [SW-1:0] S_LAST = SW'(N_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_BIT - 1);

    logic rx_s;
    logic fall;
    logic maj;
    logic good_frame;

    uart_state_e      state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [NW-1:0]    n_q, n_d;
    logic [N_BIT-1:0] b_q, b_d;
    logic [1:0]       win_q, win_d;
    logic [N_BIT-1:0] dout_q, dout_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;

    uart_rx_sync u_sync (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .rx_i   (RX),
        .rx_s_o (rx_s),
        .fall_o (fall)
    );

    // Vote over the two previous tick samples and the current line level.
    assign maj = maj3(win_q[1], win_q[0], rx_s);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            win_q   <= '1;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            win_q   <= win_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        b_d        = b_q;
        win_d      = win_q;
        good_frame = 1'b0;
        ferr_d     = 1'b0;

        if (TICK) begin
            win_d = {win_q[0], rx_s};
        end

        case (state_q)
            ST_IDLE: begin
                // Edge detection runs every cycle, not only on TICK.
                if (fall) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (TICK) begin
                    if (s_q == S_MID) begin
                        if (maj) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (TICK) begin
                    if (s_q == S_LAST) begin
                        b_d = {maj, b_q[N_BIT-1:1]};
                        s_d = '0;
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (TICK) begin
                    if (s_q == S_LAST) begin
                        state_d = ST_IDLE;
                        s_d     = '0;
                        if (maj) begin
                            good_frame = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A completion coinciding with RD_ACK hands over the new word cleanly.
    always_comb begin
        dout_d  = dout_q;
        done_d  = good_frame;
        ready_d = ready_q;
        ovr_d   = ovr_q;
        if (RD_ACK) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (good_frame) begin
            dout_d  = b_q;
            ready_d = 1'b1;
            if (ready_q && !RD_ACK) begin
                ovr_d = 1'b1;
            end
        end
    end

    assign DOUT      = dout_q;
    assign RX_DONE   = done_q;
    assign RX_READY  = ready_q;
    assign OVERRUN   = ovr_q;
    assign FRAME_ERR = ferr_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: the line is described per tick slot, and a frame-level
// model derives expected state, completions and flags from bit-centre timing.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int NB    = 8;
    localparam int NT    = 16;
    localparam int TRAIL = NT * (NB + 3);

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          TICK = 1'b0;
    logic          RX = 1'b1;
    logic          RD_ACK = 1'b0;
    logic [NB-1:0] DOUT;
    logic          RX_DONE, RX_READY, OVERRUN, FRAME_ERR;
    logic [1:0]    STATE;

    uart_rx #(.N_BIT(NB), .N_TICK(NT)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .TICK(TICK), .RX(RX), .RD_ACK(RD_ACK),
        .DOUT(DOUT), .RX_DONE(RX_DONE), .RX_READY(RX_READY), .OVERRUN(OVERRUN),
        .FRAME_ERR(FRAME_ERR), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    int    n_vec = 0;
    int    n_err = 0;
    string scen  = "init";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Line level per tick slot, RD_ACK per tick slot, and line history.
    bit line[$];
    bit ackq[$];
    bit prev1 = 1'b1;
    bit prev2 = 1'b1;

    logic [1:0]    e_state[];
    bit            e_good[];
    bit            e_ferr[];
    logic [NB-1:0] e_word[];

    logic [NB-1:0] m_dout  = '0;
    bit            m_ready = 1'b0;
    bit            m_ov    = 1'b0;

    function automatic bit lv(input int t);
        if (t >= 0) return line[t];
        if (t == -1) return prev1;
        return prev2;
    endfunction

    function automatic bit vote(input int t);
        int c;
        c = int'(lv(t - 2)) + int'(lv(t - 1)) + int'(lv(t));
        return c >= 2;
    endfunction

    task automatic push_level(input int len, input bit v);
        for (int i = 0; i < len; i++) line.push_back(v);
    endtask

    task automatic push_frame(input logic [NB-1:0] w, input bit stop_bit, output int k0);
        k0 = line.size();
        push_level(NT, 1'b0);
        for (int i = 0; i < NB; i++) push_level(NT, w[i]);
        push_level(NT, stop_bit);
    endtask

    task automatic set_ack(input int k);
        while (ackq.size() <= k) ackq.push_back(1'b0);
        ackq[k] = 1'b1;
    endtask

    task automatic set_span(input int a, input int b, input logic [1:0] st);
        for (int j = a; j < b && j < e_state.size(); j++) e_state[j] = st;
    endtask

    // A falling line between idle slots starts a frame; decisions fall at
    // half a bit after the start edge and then every full bit period.
    task automatic build_expect();
        int n, t, cen, sd;
        logic [NB-1:0] w;
        n = line.size();
        e_state = new[n];
        e_good  = new[n];
        e_ferr  = new[n];
        e_word  = new[n];
        for (int i = 0; i < n; i++) begin
            e_state[i] = IDLE; e_good[i] = 1'b0; e_ferr[i] = 1'b0; e_word[i] = '0;
        end
        t = 0;
        while (t < n) begin
            if (lv(t - 1) && !lv(t)) begin
                cen = t + NT / 2;
                sd  = cen + NT * (NB + 1);
                set_span(t, cen, START);
                if (cen >= n) break;
                if (vote(cen)) begin
                    t = cen + 1;
                    continue;
                end
                set_span(cen, cen + NT * NB, DATA);
                set_span(cen + NT * NB, sd, STOP);
                if (sd >= n) break;
                w = '0;
                for (int i = 0; i < NB; i++) w[i] = vote(cen + NT * (i + 1));
                if (vote(sd)) begin
                    e_good[sd] = 1'b1;
                    e_word[sd] = w;
                end else begin
                    e_ferr[sd] = 1'b1;
                end
                t = sd + 1;
            end else begin
                t++;
            end
        end
    endtask

    task automatic check_outputs(input int k);
        check({scen, ":state"}, STATE,     (k >= 0) ? e_state[k] : IDLE);
        check({scen, ":done"},  RX_DONE,   (k >= 0) ? e_good[k]  : 1'b0);
        check({scen, ":ferr"},  FRAME_ERR, (k >= 0) ? e_ferr[k]  : 1'b0);
        check({scen, ":dout"},  DOUT,      m_dout);
        check({scen, ":ready"}, RX_READY,  m_ready);
        check({scen, ":ovr"},   OVERRUN,   m_ov);
    endtask

    task automatic run_line();
        int n;
        bit ack, was_ready, p1, p2;
        build_expect();
        n = line.size();
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            check_outputs(k - 1);
            RX = line[k]; TICK = 1'b0; RD_ACK = 1'b0;
            @(negedge CLK);
            check({scen, ":done_width"}, RX_DONE, 1'b0);
            check({scen, ":ferr_width"}, FRAME_ERR, 1'b0);
            @(negedge CLK);
            @(negedge CLK);
            ack = (k < ackq.size()) ? ackq[k] : 1'b0;
            TICK = 1'b1; RD_ACK = ack;
            was_ready = m_ready;
            if (ack) begin m_ready = 1'b0; m_ov = 1'b0; end
            if (e_good[k]) begin
                if (was_ready && !ack) m_ov = 1'b1;
                m_ready = 1'b1;
                m_dout  = e_word[k];
            end
        end
        @(negedge CLK);
        check_outputs(n - 1);
        TICK = 1'b0; RD_ACK = 1'b0;
        p2 = lv(n - 2); p1 = lv(n - 1);
        prev2 = p2; prev1 = p1;
        line.delete();
        ackq.delete();
    endtask

    initial begin
        int k0, k1, idx;
        logic [NB-1:0] w;

        RESET_N = 1'b0; RX = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst:dout", DOUT, 0);      check("rst:done", RX_DONE, 0);
        check("rst:ready", RX_READY, 0); check("rst:ovr", OVERRUN, 0);
        check("rst:ferr", FRAME_ERR, 0); check("rst:state", STATE, IDLE);
        RESET_N = 1'b1;
        @(negedge CLK);

        scen = "a5";
        push_level(5, 1'b1); push_frame(8'hA5, 1'b1, k0); push_level(TRAIL, 1'b1);
        run_line();
        check("a5:dout_final", DOUT, 8'hA5);
        check("a5:ready_final", RX_READY, 1'b1);

        scen = "glitch";
        push_level(5, 1'b1); push_level(4, 1'b0); push_level(20, 1'b1);
        run_line();

        scen = "ferr";
        push_level(5, 1'b1); push_frame(8'h3C, 1'b0, k0); push_level(40, 1'b0);
        run_line();
        check("ferr:dout_kept", DOUT, 8'hA5);

        scen = "ack0";
        push_level(6, 1'b1); set_ack(2);
        run_line();

        scen = "overrun";
        push_level(5, 1'b1); push_frame(8'h11, 1'b1, k0);
        push_level(3, 1'b1); push_frame(8'h22, 1'b1, k1); push_level(TRAIL, 1'b1);
        run_line();
        check("overrun:dout", DOUT, 8'h22);
        check("overrun:ready", RX_READY, 1'b1);
        check("overrun:ovr", OVERRUN, 1'b1);

        scen = "ack";
        push_level(6, 1'b1); set_ack(2);
        run_line();
        check("ack:ready", RX_READY, 1'b0);
        check("ack:ovr", OVERRUN, 1'b0);

        scen = "ack_coinc";
        push_level(5, 1'b1); push_frame(8'h11, 1'b1, k0);
        push_level(3, 1'b1); push_frame(8'h22, 1'b1, k1); push_level(TRAIL, 1'b1);
        set_ack(k1 + NT / 2 + NT * (NB + 1));
        run_line();
        check("ack_coinc:ready", RX_READY, 1'b1);
        check("ack_coinc:ovr", OVERRUN, 1'b0);

        scen = "spike";
        push_level(5, 1'b1); push_frame(8'h00, 1'b1, k0); push_level(TRAIL, 1'b1);
        line[k0 + NT * 4 + NT / 2] = 1'b1;
        run_line();
        check("spike:dout", DOUT, 8'h00);

        scen = "random";
        for (int f = 0; f < 12; f++) begin
            push_level($urandom_range(20, 1), 1'b1);
            w = NB'($urandom);
            push_frame(w, $urandom_range(5, 0) != 0, k0);
        end
        for (int g = 0; g < 8; g++) begin
            idx = $urandom_range(line.size() - 1, 0);
            line[idx] = ~line[idx];
        end
        push_level(TRAIL, 1'b1);
        for (int k = 0; k < line.size(); k++) if ($urandom_range(39, 0) == 0) set_ack(k);
        run_line();

        scen = "reset";
        push_level(5, 1'b1); push_frame(8'hFF, 1'b1, k0);
        while (line.size() > k0 + NT * 4) void'(line.pop_back());
        run_line();
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check("reset:dout", DOUT, 0);      check("reset:done", RX_DONE, 0);
        check("reset:ready", RX_READY, 0); check("reset:ovr", OVERRUN, 0);
        check("reset:ferr", FRAME_ERR, 0); check("reset:state", STATE, IDLE);
        RX = 1'b1;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        m_dout = '0; m_ready = 1'b0; m_ov = 1'b0; prev1 = 1'b1; prev2 = 1'b1;

        scen = "post_reset";
        push_level(5, 1'b1); push_frame(8'h5A, 1'b1, k0); push_level(TRAIL, 1'b1);
        run_line();
        check("post_reset:dout", DOUT, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
